// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared types and constants for the memory arbiter
package rv32i_pkg;

    localparam int MEM_ADDR_W = 18;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } arb_state_e;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            bmask;
        logic                  wren;
    } mem_req_t;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational 2-way select, fixed priority (port 1) or round-robin
module arb_pick
    import rv32i_pkg::*;
#(
    parameter bit RR = 1'b0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        // On a tie round-robin favours whichever port did not win last time.
        if (req0 && req1) begin
            grant_id = RR ? ~last_grant : ARB_P1;
        end else begin
            grant_id = req1 ? ARB_P1 : ARB_P0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port memory arbiter (IDLE/BUSY/GAP); MEM_ARB_RR_EN selects round-robin
module mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_p0_valid,
    output logic              o_p0_ready,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [31:0]       i_p0_wdata,
    input  logic [3:0]        i_p0_bmask,
    input  logic              i_p0_wren,
    output logic [31:0]       o_p0_rdata,
    input  logic              i_p1_valid,
    output logic              o_p1_ready,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [31:0]       i_p1_wdata,
    input  logic [3:0]        i_p1_bmask,
    input  logic              i_p1_wren,
    output logic [31:0]       o_p1_rdata,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata
);

    arb_state_e state_q, state_d;
    mem_req_t   req_q, req_sel;
    logic       gnt_q;
    logic       pick_valid, pick_id;
    logic       last_grant;
    logic       grant_now;
    logic       done;

    assign grant_now = (state_q == IDLE) && pick_valid;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
    logic last_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_q <= ARB_P1;
        end else if (grant_now) begin
            last_q <= pick_id;
        end
    end

    assign last_grant = last_q;
`else
    localparam bit RR_EN = 1'b0;
    assign last_grant = ARB_P1;
`endif

    arb_pick #(
        .RR(RR_EN)
    ) u_pick (
        .req0       (i_p0_valid),
        .req1       (i_p1_valid),
        .last_grant (last_grant),
        .grant_valid(pick_valid),
        .grant_id   (pick_id)
    );

    always_comb begin
        if (pick_id == ARB_P1) begin
            req_sel.addr  = MEM_ADDR_W'(i_p1_addr);
            req_sel.wdata = i_p1_wdata;
            req_sel.bmask = i_p1_bmask;
            req_sel.wren  = i_p1_wren;
        end else begin
            req_sel.addr  = MEM_ADDR_W'(i_p0_addr);
            req_sel.wdata = i_p0_wdata;
            req_sel.bmask = i_p0_bmask;
            req_sel.wren  = i_p0_wren;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = BUSY;
            BUSY:    if (i_mem_ready) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            gnt_q   <= ARB_P0;
        end else begin
            state_q <= state_d;
            if (grant_now) begin
                req_q <= req_sel;
                gnt_q <= pick_id;
            end
        end
    end

    // Gate with reset so an abandoned transaction never reports completion.
    assign done        = (state_q == BUSY) && i_mem_ready && i_rst_n;
    assign o_p0_ready  = done && (gnt_q == ARB_P0);
    assign o_p1_ready  = done && (gnt_q == ARB_P1);
    assign o_p0_rdata  = i_mem_rdata;
    assign o_p1_rdata  = i_mem_rdata;

    assign o_mem_valid = (state_q == BUSY);
    assign o_mem_addr  = ADDR_W'(req_q.addr);
    assign o_mem_wdata = req_q.wdata;
    assign o_mem_bmask = req_q.bmask;
    assign o_mem_wren  = req_q.wren;

endmodule
